// File: rtl/core_apb_bridge.sv
// rtl/core_apb_bridge.sv - core memory port to APB4 bridge with lane steering, decode and timeout
module core_apb_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mem_en,
  input  logic                   mem_we,
  input  logic [ADDR_W-1:0]      mem_adr,
  input  logic [DATA_W-1:0]      mem_wdata,
  input  logic [1:0]             mem_len,
  output logic [DATA_W-1:0]      mem_rdata,
  output logic                   mem_ready,
  output logic                   mem_err,
  output logic [NSLV-1:0]        psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  output logic [DATA_W/8-1:0]    pstrb,
  input  logic [NSLV*DATA_W-1:0] prdata,
  input  logic [NSLV-1:0]        pready,
  input  logic [NSLV-1:0]        pslverr
);

  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);
  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t state, state_nx;

  logic [SW-1:0]     sidx, sidx_q;
  logic [LW-1:0]     off, off_q;
  logic [1:0]        len_q;
  logic [CW-1:0]     cnt_q;
  logic              err_q;
  logic              req_bad;
  logic              timeout_hit;
  logic [DATA_W-1:0] wdata_st;
  logic [NB-1:0]     strb_st;
  logic              sel_rdy, sel_err;
  logic [DATA_W-1:0] sel_rdata, rd_shift, rd_mask;
  logic [NSLV-1:0]   psel_dec;

  // Request decode and write lane steering, evaluated on the live request in IDLE
  always_comb begin
    sidx     = mem_adr[SEL_LSB +: SW];
    off      = mem_adr[LW-1:0];
    req_bad  = (mem_len == 2'b11)
             | ((mem_len == 2'b01) & mem_adr[0])
             | ((mem_len == 2'b10) & (|mem_adr[1:0]))
             | (32'(sidx) >= NSLV);
    wdata_st = '0;
    strb_st  = '0;
    case (mem_len)
      2'b00: begin
        wdata_st = {(DATA_W/8){mem_wdata[7:0]}};
        strb_st  = NB'(1) << off;
      end
      2'b01: begin
        wdata_st = {(DATA_W/16){mem_wdata[15:0]}};
        strb_st  = NB'(3) << off;
      end
      default: begin
        wdata_st = {(DATA_W/32){mem_wdata[31:0]}};
        strb_st  = NB'(15) << off;
      end
    endcase
  end

  // Only the addressed slave's handshake and data are ever observed
  always_comb begin
    sel_rdy   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    psel_dec  = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sidx_q == SW'(i)) begin
        sel_rdy     = pready[i];
        sel_err     = pslverr[i];
        sel_rdata   = prdata[i*DATA_W +: DATA_W];
        psel_dec[i] = 1'b1;
      end
    end
    rd_shift = sel_rdata >> {off_q, 3'b000};
    rd_mask  = '0;
    case (len_q)
      2'b00:   rd_mask[7:0]  = '1;
      2'b01:   rd_mask[15:0] = '1;
      default: rd_mask[31:0] = '1;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

  always_comb begin
    state_nx  = state;
    psel      = '0;
    penable   = 1'b0;
    mem_ready = 1'b0;
    mem_err   = 1'b0;
    case (state)
      IDLE:   if (mem_en) state_nx = req_bad ? DONE : SETUP;
      SETUP: begin
        psel     = psel_dec;
        state_nx = ACCESS;
      end
      ACCESS: begin
        psel    = psel_dec;
        penable = 1'b1;
        if (sel_rdy || timeout_hit) state_nx = DONE;
      end
      DONE: begin
        mem_ready = 1'b1;
        mem_err   = err_q;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sidx_q    <= '0;
      off_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (mem_en) begin
          err_q     <= req_bad;
          mem_rdata <= '0;
          sidx_q    <= sidx;
          off_q     <= off;
          len_q     <= mem_len;
          // APB fields only move on an accepted request, so they stay stable through ACCESS
          if (!req_bad) begin
            pwrite <= mem_we;
            paddr  <= {mem_adr[ADDR_W-1:LW], {LW{1'b0}}};
            pwdata <= mem_we ? wdata_st : '0;
            pstrb  <= mem_we ? strb_st : '0;
          end
        end
        SETUP: cnt_q <= '0;
        ACCESS: begin
          if (sel_rdy) begin
            err_q <= sel_err;
            if (!pwrite && !sel_err) mem_rdata <= rd_shift & rd_mask;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_apb_bridge.sv
// tb/tb_core_apb_bridge.sv - directed self-checking bench for core_apb_bridge
module tb_core_apb_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, mem_en, mem_en3, mem_we;
  logic [31:0]  mem_adr, mem_wdata;
  logic [1:0]   mem_len;
  logic [31:0]  mem_rdata, mem_rdata3;
  logic         mem_ready, mem_err, mem_ready3, mem_err3;
  logic [3:0]   psel;
  logic [2:0]   psel3;
  logic         penable, pwrite, penable3, pwrite3;
  logic [31:0]  paddr, paddr3, pwdata, pwdata3;
  logic [3:0]   pstrb, pstrb3;
  logic [127:0] prdata;
  logic [3:0]   pready, pslverr;
  int           total = 0, bad = 0, n;

  core_apb_bridge #(.NSLV(4), .TIMEOUT(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_err(mem_err), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr));

  core_apb_bridge #(.NSLV(3), .TIMEOUT(0)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .mem_en(mem_en3), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_rdata(mem_rdata3), .mem_ready(mem_ready3),
    .mem_err(mem_err3), .psel(psel3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3),
    .pwdata(pwdata3), .pstrb(pstrb3), .prdata(prdata[95:0]), .pready(pready[2:0]),
    .pslverr(pslverr[2:0]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic [1:0] len);
    mem_we    = we;
    mem_adr   = adr;
    mem_wdata = wd;
    mem_len   = len;
    mem_en    = 1'b1;
  endtask

  task automatic wait_ready(input int bound, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!mem_ready && cyc < bound);
  endtask

  initial begin
    reset_n = 1'b0; mem_en = 1'b0; mem_en3 = 1'b0; mem_we = 1'b0;
    mem_adr = '0; mem_wdata = '0; mem_len = 2'b10;
    prdata = '0; pready = 4'hF; pslverr = 4'h0;
    step(); step();
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb", pstrb, 0);
    chk("rst_rdy_err_rdata", {mem_ready, mem_err, mem_rdata}, 0);
    reset_n = 1'b1;
    step();

    // word write, zero waits
    req(1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 2'b10);
    step();
    chk("w_setup_psel", psel, 4'b0100);
    chk("w_setup_penable", penable, 0);
    chk("w_pwrite", pwrite, 1);
    chk("w_paddr", paddr, 32'h2004);
    chk("w_pstrb", pstrb, 4'hF);
    chk("w_pwdata", pwdata, 32'hDEAD_BEEF);
    step();
    chk("w_access", {psel, penable}, {4'b0100, 1'b1});
    step();
    chk("w_ready_c3", {mem_ready, mem_err}, 2'b10);
    mem_en = 1'b0;
    step();
    chk("w_idle", {mem_ready, psel}, 0);

    // byte write at lane 3
    req(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'b00);
    step();
    chk("b_psel", psel, 4'b0010);
    chk("b_pstrb", pstrb, 4'b1000);
    chk("b_pwdata", pwdata, 32'hA5A5_A5A5);
    chk("b_paddr", paddr, 32'h1000);
    wait_ready(20, n);
    chk("b_lat", n, 2);
    mem_en = 1'b0;
    step();

    // half read at offset 2; unselected slave error must be ignored
    prdata[63:32] = 32'h1234_5678;
    pslverr[3] = 1'b1;
    req(1'b0, 32'h0000_1002, 32'hFFFF_FFFF, 2'b01);
    step();
    chk("h_pstrb", pstrb, 0);
    chk("h_pwrite", pwrite, 0);
    wait_ready(20, n);
    chk("h_lat", n, 2);
    chk("h_rdata", mem_rdata, 32'h0000_1234);
    chk("h_err", mem_err, 0);
    mem_en = 1'b0;
    pslverr[3] = 1'b0;
    step();

    // byte read at offset 1
    prdata[95:64] = 32'hCAFE_F00D;
    req(1'b0, 32'h0000_2001, 32'h0, 2'b00);
    wait_ready(20, n);
    chk("br_lat", n, 3);
    chk("br_rdata", mem_rdata, 32'h0000_00F0);
    mem_en = 1'b0;
    step();

    // slave 0: three wait states then slave error
    prdata[31:0] = 32'h1111_2222;
    pready[0] = 1'b0;
    req(1'b0, 32'h0000_0008, 32'h0, 2'b10);
    step(); step();
    chk("ws_pen_c2", penable, 1);
    step(); step();
    chk("ws_pen_c4", {penable, mem_ready}, 2'b10);
    step();
    pready[0] = 1'b1;
    pslverr[0] = 1'b1;
    chk("ws_pen_c5", {psel, penable}, {4'b0001, 1'b1});
    step();
    chk("ws_ready_c6", {mem_ready, mem_err}, 2'b11);
    chk("ws_rdata", mem_rdata, 0);
    mem_en = 1'b0;
    pslverr[0] = 1'b0;
    step();

    // request check errors
    req(1'b0, 32'h0000_0002, 32'h0, 2'b10);
    step();
    chk("mis_w", {mem_ready, mem_err, psel, mem_rdata}, {2'b11, 4'b0, 32'h0});
    mem_en = 1'b0;
    step();
    req(1'b1, 32'h0000_0000, 32'h0, 2'b11);
    step();
    chk("len11", {mem_ready, mem_err, psel}, {2'b11, 4'b0});
    mem_en = 1'b0;
    step();
    req(1'b0, 32'h0000_1001, 32'h0, 2'b01);
    step();
    chk("mis_h", {mem_ready, mem_err, psel}, {2'b11, 4'b0});
    mem_en = 1'b0;
    step();

    // NSLV=3 instance: decode error at slave index 3, normal access at index 2
    mem_we = 1'b0; mem_adr = 32'h0000_3000; mem_len = 2'b10;
    mem_en3 = 1'b1;
    step();
    chk("dec3", {mem_ready3, mem_err3, psel3}, {2'b11, 3'b0});
    mem_en3 = 1'b0;
    step();
    mem_adr = 32'h0000_2000;
    mem_en3 = 1'b1;
    step();
    chk("n3_psel", psel3, 3'b100);
    step(); step();
    chk("n3_done", {mem_ready3, mem_err3, mem_rdata3}, {2'b10, 32'hCAFE_F00D});
    mem_en3 = 1'b0;
    step();

    // timeout on slave 3
    pready[3] = 1'b0;
    req(1'b0, 32'h0000_3000, 32'h0, 2'b10);
    n = 0;
    do begin
      step();
      n++;
      if (n == 18) chk("to_c18", {psel, penable}, {4'b1000, 1'b1});
    end while (!mem_ready && n < 40);
    chk("to_lat", n, 19);
    chk("to_err", {mem_err, psel, penable, mem_rdata}, {1'b1, 4'b0, 1'b0, 32'h0});
    mem_en = 1'b0;
    pready[3] = 1'b1;
    step();

    // reset in ACCESS aborts without completion
    req(1'b0, 32'h0000_1000, 32'h0, 2'b10);
    step(); step();
    chk("ab_access", penable, 1);
    reset_n = 1'b0;
    mem_en = 1'b0;
    #1;
    chk("ab_outs", {psel, penable, pwrite, paddr, mem_ready, mem_err}, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("ab_no_ready", mem_ready, 0);
    req(1'b0, 32'h0000_2000, 32'h0, 2'b10);
    wait_ready(20, n);
    chk("ab_new_lat", n, 3);
    chk("ab_new_data", {mem_err, mem_rdata}, {1'b0, 32'hCAFE_F00D});
    mem_en = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
